ei_axi4_protocol_checker: RTL and testbench

- Synthesizable, parametrised AXI4 protocol checker, bound passively beside the VIP interface; all AXI pins are inputs only.
- Tracks outstanding bursts, checks per-channel payload stability, WLAST/RLAST position and B/R response ordering.
- Reports sticky error bits, first-error code and a saturating error count for scoreboard/regression use.

---
 rtl/ei_axi4_chk_pkg.sv | 37 +++
 rtl/ei_axi4_len_fifo.sv | 53 +++++
 rtl/ei_axi4_protocol_checker.sv | 206 ++++++++++++++++++++
 tb/tb_ei_axi4_protocol_checker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ei_axi4_chk_pkg.sv
// Shared types for the AXI4 protocol checker: error bit indices, burst-length
// type and a lowest-set-bit helper used for first-error capture.
package ei_axi4_chk_pkg;

    localparam int ERR_W   = 16;
    localparam int WDONE_W = 8;

    typedef enum logic [3:0] {
        ERR_AW_STABLE     = 4'd0,
        ERR_W_STABLE      = 4'd1,
        ERR_B_STABLE      = 4'd2,
        ERR_AR_STABLE     = 4'd3,
        ERR_R_STABLE      = 4'd4,
        ERR_WLAST_EARLY   = 4'd5,
        ERR_WLAST_MISSING = 4'd6,
        ERR_W_NO_AW       = 4'd7,
        ERR_B_NO_WDONE    = 4'd8,
        ERR_RLAST_EARLY   = 4'd9,
        ERR_RLAST_MISSING = 4'd10,
        ERR_R_NO_AR       = 4'd11,
        ERR_AW_OVF        = 4'd12,
        ERR_AR_OVF        = 4'd13,
        ERR_VALID_DROP    = 4'd14,
        ERR_WDONE_OVF     = 4'd15
    } err_idx_e;

    // 9 bits so that len+1 = 256 fits
    typedef logic [8:0] burst_len_t;

    function automatic logic [3:0] lowest_set(input logic [ERR_W-1:0] v);
        lowest_set = 4'd0;
        for (int i = ERR_W - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction

endpackage

// File: rtl/ei_axi4_len_fifo.sv
// Small FIFO holding AxLEN of accepted address phases until their data burst
// completes. Simultaneous push/pop is allowed; push is dropped only if still full after the pop.
module ei_axi4_len_fifo
    import ei_axi4_chk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     temp_aresetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign head    = mem[rptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge aclk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge aclk or negedge temp_aresetn) begin
        if (!temp_aresetn) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ei_axi4_protocol_checker.sv
// Passive AXI4 protocol checker: payload stability, xLAST position, response
// ordering and outstanding-burst tracking, with sticky/first/count error reporting.
module ei_axi4_protocol_checker
    import ei_axi4_chk_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int MAX_OUTST     = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                         aclk,
    input  logic                         temp_aresetn,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [7:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    input  logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    input  logic                         wready,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_WIDTH-1:0]        araddr,
    input  logic [7:0]                   arlen,
    input  logic [2:0]                   arsize,
    input  logic [1:0]                   arburst,
    input  logic                         arvalid,
    input  logic                         arready,
    input  logic [DATA_WIDTH-1:0]        rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    input  logic                         rready,
    input  logic                         chk_en,
    input  logic                         clr_err,
    output logic [ERR_W-1:0]             err_vec,
    output logic                         err_pulse,
    output logic [3:0]                   err_first_code,
    output logic [ERR_CNT_WIDTH-1:0]     err_count,
    output logic [$clog2(MAX_OUTST):0]   wr_outst,
    output logic [$clog2(MAX_OUTST):0]   rd_outst
);
    localparam int AW_PL_W = ADDR_WIDTH + 13;
    localparam int W_PL_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int R_PL_W  = DATA_WIDTH + 3;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    logic [AW_PL_W-1:0] aw_pl, aw_cap;
    logic [W_PL_W-1:0]  w_pl, w_cap;
    logic [1:0]         b_cap;
    logic [AW_PL_W-1:0] ar_pl, ar_cap;
    logic [R_PL_W-1:0]  r_pl, r_cap;
    logic               aw_pend, w_pend, b_pend, ar_pend, r_pend;

    assign aw_pl = {awaddr, awlen, awsize, awburst};
    assign w_pl  = {wdata, wstrb, wlast};
    assign ar_pl = {araddr, arlen, arsize, arburst};
    assign r_pl  = {rdata, rresp, rlast};

    // A stalled transfer arms the next-edge stability check on its channel
    always_ff @(posedge aclk or negedge temp_aresetn) begin
        if (!temp_aresetn) begin
            {aw_pend, w_pend, b_pend, ar_pend, r_pend} <= '0;
            aw_cap <= '0;
            w_cap  <= '0;
            b_cap  <= '0;
            ar_cap <= '0;
            r_cap  <= '0;
        end else begin
            aw_pend <= awvalid && !awready;
            w_pend  <= wvalid && !wready;
            b_pend  <= bvalid && !bready;
            ar_pend <= arvalid && !arready;
            r_pend  <= rvalid && !rready;
            aw_cap  <= aw_pl;
            w_cap   <= w_pl;
            b_cap   <= bresp;
            ar_cap  <= ar_pl;
            r_cap   <= r_pl;
        end
    end

    logic [7:0]                 aw_head, ar_head;
    logic                       aw_full, aw_empty, ar_full, ar_empty;
    logic                       aw_push, aw_pop, ar_push, ar_pop;
    burst_len_t                 wcnt, rcnt, wcnt_p1, rcnt_p1, w_len, r_len;
    logic                       w_have, w_bypass, w_beat, w_done;
    logic                       r_have, r_bypass, r_beat, r_done;
    logic [WDONE_W-1:0]         wdone;
    logic                       b_dec;

    // Bypass lets a W/R beat consume an address accepted at the same edge
    assign w_have   = !aw_empty || aw_hs;
    assign w_bypass = aw_empty && aw_hs;
    assign w_len    = burst_len_t'({1'b0, (w_bypass ? awlen : aw_head)}) + 9'd1;
    assign wcnt_p1  = wcnt + 9'd1;
    assign w_beat   = w_hs && w_have;
    assign w_done   = w_beat && (wlast || (wcnt_p1 == w_len));
    assign aw_pop   = w_done && !w_bypass;
    assign aw_push  = aw_hs && !(w_done && w_bypass);

    assign r_have   = !ar_empty || ar_hs;
    assign r_bypass = ar_empty && ar_hs;
    assign r_len    = burst_len_t'({1'b0, (r_bypass ? arlen : ar_head)}) + 9'd1;
    assign rcnt_p1  = rcnt + 9'd1;
    assign r_beat   = r_hs && r_have;
    assign r_done   = r_beat && (rlast || (rcnt_p1 == r_len));
    assign ar_pop   = r_done && !r_bypass;
    assign ar_push  = ar_hs && !(r_done && r_bypass);

    assign b_dec    = b_hs && (wdone != '0);

    ei_axi4_len_fifo #(.WIDTH(8), .DEPTH(MAX_OUTST)) u_aw_fifo (
        .aclk(aclk), .temp_aresetn(temp_aresetn),
        .push(aw_push), .din(awlen), .pop(aw_pop),
        .head(aw_head), .full(aw_full), .empty(aw_empty), .count(wr_outst)
    );

    ei_axi4_len_fifo #(.WIDTH(8), .DEPTH(MAX_OUTST)) u_ar_fifo (
        .aclk(aclk), .temp_aresetn(temp_aresetn),
        .push(ar_push), .din(arlen), .pop(ar_pop),
        .head(ar_head), .full(ar_full), .empty(ar_empty), .count(rd_outst)
    );

    always_ff @(posedge aclk or negedge temp_aresetn) begin
        if (!temp_aresetn) begin
            wcnt  <= '0;
            rcnt  <= '0;
            wdone <= '0;
        end else begin
            if (w_done)      wcnt <= '0;
            else if (w_beat) wcnt <= wcnt_p1;
            if (r_done)      rcnt <= '0;
            else if (r_beat) rcnt <= rcnt_p1;
            case ({w_done, b_dec})
                2'b10:   if (wdone != '1) wdone <= wdone + 1'b1;
                2'b01:   wdone <= wdone - 1'b1;
                default: wdone <= wdone;
            endcase
        end
    end

    logic [ERR_W-1:0] err_now;

    always_comb begin
        err_now = '0;
        err_now[ERR_AW_STABLE]     = aw_pend && awvalid && (aw_pl != aw_cap);
        err_now[ERR_W_STABLE]      = w_pend && wvalid && (w_pl != w_cap);
        err_now[ERR_B_STABLE]      = b_pend && bvalid && (bresp != b_cap);
        err_now[ERR_AR_STABLE]     = ar_pend && arvalid && (ar_pl != ar_cap);
        err_now[ERR_R_STABLE]      = r_pend && rvalid && (r_pl != r_cap);
        err_now[ERR_VALID_DROP]    = (aw_pend && !awvalid) || (w_pend && !wvalid) ||
                                     (b_pend && !bvalid) || (ar_pend && !arvalid) ||
                                     (r_pend && !rvalid);
        err_now[ERR_WLAST_EARLY]   = w_beat && wlast && (wcnt_p1 < w_len);
        err_now[ERR_WLAST_MISSING] = w_beat && !wlast && (wcnt_p1 == w_len);
        err_now[ERR_W_NO_AW]       = w_hs && !w_have;
        err_now[ERR_B_NO_WDONE]    = b_hs && (wdone == '0);
        err_now[ERR_RLAST_EARLY]   = r_beat && rlast && (rcnt_p1 < r_len);
        err_now[ERR_RLAST_MISSING] = r_beat && !rlast && (rcnt_p1 == r_len);
        err_now[ERR_R_NO_AR]       = r_hs && !r_have;
        err_now[ERR_AW_OVF]        = aw_hs && aw_full && !aw_pop;
        err_now[ERR_AR_OVF]        = ar_hs && ar_full && !ar_pop;
        err_now[ERR_WDONE_OVF]     = w_done && !b_dec && (wdone == '1);
    end

    logic [ERR_W-1:0] err_rec;
    logic             first_vld;
    assign err_rec = chk_en ? err_now : '0;

    // clr_err wipes the history first so a same-edge error is recorded afresh
    always_ff @(posedge aclk or negedge temp_aresetn) begin
        if (!temp_aresetn) begin
            err_vec        <= '0;
            err_pulse      <= 1'b0;
            err_first_code <= '0;
            first_vld      <= 1'b0;
            err_count      <= '0;
        end else begin
            err_pulse <= |err_rec;
            err_vec   <= (clr_err ? '0 : err_vec) | err_rec;
            if ((clr_err || !first_vld) && (|err_rec)) begin
                err_first_code <= lowest_set(err_rec);
                first_vld      <= 1'b1;
            end else if (clr_err) begin
                err_first_code <= '0;
                first_vld      <= 1'b0;
            end
            if (clr_err)
                err_count <= (|err_rec) ? ERR_CNT_WIDTH'(1) : '0;
            else if ((|err_rec) && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ei_axi4_protocol_checker.sv
// Directed bench for ei_axi4_protocol_checker with hand-computed expectations
// checked by immediate assertions after each clock edge.
module tb_ei_axi4_protocol_checker;

    logic        aclk = 1'b0;
    logic        temp_aresetn;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wvalid, wready, wlast;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;
    logic        chk_en, clr_err;
    logic [15:0] err_vec;
    logic        err_pulse;
    logic [3:0]  err_first_code;
    logic [15:0] err_count;
    logic [2:0]  wr_outst, rd_outst;

    int vectors    = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    ei_axi4_protocol_checker dut (
        .aclk(aclk), .temp_aresetn(temp_aresetn),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .chk_en(chk_en), .clr_err(clr_err),
        .err_vec(err_vec), .err_pulse(err_pulse), .err_first_code(err_first_code),
        .err_count(err_count), .wr_outst(wr_outst), .rd_outst(rd_outst)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        temp_aresetn = 1'b0;
        awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'd1;
        awvalid = 0; awready = 1;
        wdata = '0; wstrb = '1; wlast = 0; wvalid = 0; wready = 1;
        bresp = '0; bvalid = 0; bready = 1;
        araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'd1;
        arvalid = 0; arready = 1;
        rdata = '0; rresp = '0; rlast = 0; rvalid = 0; rready = 1;
        chk_en = 1; clr_err = 0;
        tick();
        chk("rst_err_vec",   32'(err_vec), 32'h0);
        chk("rst_count",     32'(err_count), 32'h0);
        chk("rst_first",     32'(err_first_code), 32'h0);
        chk("rst_pulse",     32'(err_pulse), 32'h0);
        chk("rst_wr_outst",  32'(wr_outst), 32'h0);
        chk("rst_rd_outst",  32'(rd_outst), 32'h0);
        temp_aresetn = 1'b1;
        tick();

        // Clean 4-beat write
        awvalid = 1; awlen = 8'd3; tick(); awvalid = 0;
        chk("t1_wr_outst_1", 32'(wr_outst), 32'd1);
        wvalid = 1; wlast = 0; tick(); tick(); tick();
        wlast = 1; tick(); wvalid = 0; wlast = 0;
        chk("t1_wr_outst_0", 32'(wr_outst), 32'd0);
        chk("t1_err_vec_w",  32'(err_vec), 32'h0);
        bvalid = 1; tick(); bvalid = 0;
        chk("t1_err_vec_b",  32'(err_vec), 32'h0);
        chk("t1_pulse",      32'(err_pulse), 32'h0);

        // Early WLAST on beat 2 of 4
        awvalid = 1; awlen = 8'd3; tick(); awvalid = 0;
        wvalid = 1; wlast = 0; tick();
        wlast = 1; tick(); wvalid = 0; wlast = 0;
        chk("t2_err_vec",    32'(err_vec), 32'h0020);
        chk("t2_pulse",      32'(err_pulse), 32'h1);
        chk("t2_first",      32'(err_first_code), 32'd5);
        chk("t2_count",      32'(err_count), 32'd1);
        chk("t2_wr_outst",   32'(wr_outst), 32'd0);
        bvalid = 1; tick(); bvalid = 0;
        chk("t2_b_ok_vec",   32'(err_vec), 32'h0020);
        chk("t2_b_ok_count", 32'(err_count), 32'd1);

        // AW payload change while stalled, then W valid drop
        clr_err = 1; tick(); clr_err = 0;
        chk("t3_clr_vec",    32'(err_vec), 32'h0);
        chk("t3_clr_count",  32'(err_count), 32'h0);
        awvalid = 1; awready = 0; awlen = 8'd0; awaddr = 32'h100; tick();
        chk("t3_no_err_yet", 32'(err_vec), 32'h0);
        awaddr = 32'h104; tick();
        chk("t3_aw_stable",  32'(err_vec), 32'h0001);
        chk("t3_pulse_hi",   32'(err_pulse), 32'h1);
        tick();
        chk("t3_pulse_lo",   32'(err_pulse), 32'h0);
        awready = 1; tick(); awvalid = 0;
        chk("t3_wr_outst",   32'(wr_outst), 32'd1);
        wvalid = 1; wready = 0; wlast = 1; wdata = 64'h5; tick();
        wvalid = 0; tick();
        chk("t3_valid_drop", 32'(err_vec), 32'h4001);
        wvalid = 1; wready = 1; tick(); wvalid = 0; wlast = 0;
        chk("t3_wr_drain",   32'(wr_outst), 32'd0);
        bvalid = 1; tick(); bvalid = 0;
        chk("t3_vec_after_b", 32'(err_vec), 32'h4001);
        chk("t3_count",      32'(err_count), 32'd2);
        chk("t3_first",      32'(err_first_code), 32'd0);

        // AR FIFO overflow and B without a completed write
        clr_err = 1; tick(); clr_err = 0;
        arvalid = 1; arlen = 8'd0; tick(); tick(); tick(); tick();
        chk("t4_rd_outst_4", 32'(rd_outst), 32'd4);
        chk("t4_no_ovf_yet", 32'(err_vec), 32'h0);
        tick(); arvalid = 0;
        chk("t4_ar_ovf",     32'(err_vec), 32'h2000);
        chk("t4_rd_outst_sat", 32'(rd_outst), 32'd4);
        bvalid = 1; tick(); bvalid = 0;
        chk("t4_b_no_wdone", 32'(err_vec), 32'h2100);

        // RLAST missing, R with no AR, then masked replay
        rvalid = 1; rlast = 0; tick();
        chk("t5_rlast_miss", 32'(err_vec), 32'h2500);
        chk("t5_rd_outst_3", 32'(rd_outst), 32'd3);
        rlast = 1; tick(); tick(); tick();
        chk("t5_rd_outst_0", 32'(rd_outst), 32'd0);
        chk("t5_clean_drain", 32'(err_vec), 32'h2500);
        tick();
        chk("t5_r_no_ar",    32'(err_vec), 32'h2D00);
        chk("t5_count",      32'(err_count), 32'd4);
        chk("t5_first",      32'(err_first_code), 32'd13);
        chk_en = 0; bvalid = 1; tick();
        chk("t5_masked_vec",   32'(err_vec), 32'h2D00);
        chk("t5_masked_pulse", 32'(err_pulse), 32'h0);
        chk("t5_masked_count", 32'(err_count), 32'd4);
        rvalid = 0; rlast = 0; bvalid = 0; chk_en = 1;

        // Reset in the middle of a 4-beat write
        awvalid = 1; awlen = 8'd3; tick(); awvalid = 0;
        wvalid = 1; wlast = 0; tick(); tick();
        #2 temp_aresetn = 1'b0;
        #1;
        chk("t6_rst_vec",      32'(err_vec), 32'h0);
        chk("t6_rst_count",    32'(err_count), 32'h0);
        chk("t6_rst_wr_outst", 32'(wr_outst), 32'h0);
        chk("t6_rst_rd_outst", 32'(rd_outst), 32'h0);
        wvalid = 0;
        tick();
        temp_aresetn = 1'b1;
        awvalid = 1; awlen = 8'd0; wvalid = 1; wlast = 1; tick();
        awvalid = 0; wvalid = 0; wlast = 0;
        chk("t6_bypass_outst", 32'(wr_outst), 32'd0);
        chk("t6_bypass_vec",   32'(err_vec), 32'h0);
        bvalid = 1; tick(); bvalid = 0;
        chk("t6_b_vec",        32'(err_vec), 32'h0);
        chk("t6_b_pulse",      32'(err_pulse), 32'h0);
        rvalid = 1; rlast = 1; tick(); rvalid = 0; rlast = 0;
        chk("t6_r_no_ar",      32'(err_vec), 32'h0800);
        chk("t6_count_1",      32'(err_count), 32'd1);
        clr_err = 1; bvalid = 1; tick(); clr_err = 0; bvalid = 0;
        chk("t6_clr_new_vec",   32'(err_vec), 32'h0100);
        chk("t6_clr_new_count", 32'(err_count), 32'd1);
        chk("t6_clr_new_first", 32'(err_first_code), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
